pattern_detector_param: RTL
===========================

PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default 8: width of the match counter in bits.
REQ-003 Parameter LW = $clog2(MAX_LEN+1), derived and not overridable: width of the length fields.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  Reset, asynchronous and active-low.
REQ-006 en  input  1  Sample strobe; x is consumed only in cycles where en=1.
REQ-007 x  input  1  Serial data bit.
REQ-008 cfg_load  input  1  Latch cfg_pattern, cfg_len and cfg_overlap.
REQ-009 cfg_pattern  input  MAX_LEN  Target pattern; bit [len-1] is the first bit received, bit [0] the last.
REQ-010 cfg_len  input  LW  Pattern length.
REQ-011 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 clr_count  input  1  Synchronous clear of match_count.
REQ-013 match  output  1  Moore detect flag, registered, one cycle wide per detection.
REQ-014 match_count  output  CNT_W  Saturating count of detections.
REQ-015 fill  output  LW  Number of valid history bits; saturates at len.

Function
REQ-016 Internal state SHALL be: pat_r (MAX_LEN), len_r (LW), ovl_r (1), hist (MAX_LEN shift register), fill, match, match_count.
REQ-017 When cfg_load=1, the block SHALL latch pat_r, len_r and ovl_r, and clear hist, fill and match in the same edge; match_count is unchanged.
REQ-018 A cfg_len of 0 or 1 SHALL be latched as 2; a cfg_len greater than MAX_LEN SHALL be latched as MAX_LEN.
REQ-019 cfg_load SHALL take priority over en; x is discarded in a load cycle.
REQ-020 In a cycle with en=1 and cfg_load=0, the block SHALL compute hist_n = {hist[MAX_LEN-2:0], x} and fill_n = min(fill+1, len_r).
REQ-021 A hit SHALL occur when fill_n == len_r and hist_n[len_r-1:0] == pat_r[len_r-1:0].
REQ-022 On the edge that samples the last pattern bit, match SHALL be registered to the hit value, so match is high in the following cycle (latency 1).
REQ-023 Overlap mode (ovl_r=1): on a hit, fill SHALL take fill_n, so history bits may be shared between successive matches.
REQ-024 Non-overlap mode (ovl_r=0): on a hit, fill SHALL be set to 0, so the next match needs len_r fresh bits.
REQ-025 In a cycle with en=0, hist and fill SHALL hold, and match SHALL be 0.
REQ-026 On a hit, match_count SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-027 When clr_count=1, match_count SHALL become 0; a simultaneous hit SHALL load 1.
REQ-028 match SHALL depend only on registered state, never combinationally on x.

Reset
REQ-029 While rst_n=0, outputs SHALL be: match=0, match_count=0, fill=0; hist SHALL be 0.
REQ-030 Reset SHALL set pat_r = 'b1011 (zero-extended), len_r = 4 and ovl_r = 1, so the default mode detects 1011 with overlap.
REQ-031 Reset asserted mid-sequence SHALL discard partial history; the first match after release needs len_r new bits.

Verification
REQ-032 Reset defaults, en=1, x = 1,0,1,1,0,1,1 -> match high in the cycles after bits 4 and 7; match_count = 2.
REQ-033 Load pattern 1011 / len 4 with cfg_overlap=0, same stream -> a single match after bit 4; match_count = 1; fill = 3 at the end.
REQ-034 Load pattern 8'b1100_1010 / len 8 (MAX_LEN=8), stream 1,1,0,0,1,0,1,0 with en deasserted for 3 cycles mid-stream -> one match after the 8th enabled bit; match = 0 during the en=0 cycles.
REQ-035 CNT_W=2, 5 overlapping hits of pattern 11 (len 2) -> match_count saturates at 3; clr_count asserted together with a hit -> match_count = 1.
REQ-036 cfg_len=0 -> latched len 2; cfg_len=15 with MAX_LEN=8 -> latched len 8; cfg_load issued mid-pattern -> fill = 0 and no stale match.
REQ-037 rst_n pulsed low after 3 bits of 1011 -> all outputs 0 immediately (asynchronous); then 1,0,1,1 -> exactly one match.

Source files
------------

// File: rtl/pattern_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// It has a registered Moore match flag, a saturating match counter and a history fill level.
module pattern_detector_param #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LW      = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [LW-1:0]      fill
);

  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MIN = LW'(2);
  localparam logic [LW-1:0] LEN_RST =
    LW'((MAX_LEN < 4) ? MAX_LEN : 4);
  localparam logic [MAX_LEN-1:0] PAT_RST =
    MAX_LEN'(4'b1011);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_n;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill_n;
  logic [LW-1:0]      len_c;
  logic               hit;

  always_comb begin
    len_c = cfg_len;
    if (cfg_len < LEN_MIN)
      len_c = LEN_MIN;
    else if (cfg_len > LEN_MAX)
      len_c = LEN_MAX;
    hist_n = {hist[MAX_LEN-2:0], x};
    fill_n = (fill >= len_r) ? len_r
                             : fill + LW'(1);
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len_r));
    // only the low len_r history bits take part
    hit = en && !cfg_load &&
          (fill_n == len_r) &&
          (((hist_n ^ pat_r) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r <= PAT_RST;
      len_r <= LEN_RST;
      ovl_r <= 1'b1;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (cfg_load) begin
      pat_r <= cfg_pattern;
      len_r <= len_c;
      ovl_r <= cfg_overlap;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (en) begin
      hist  <= hist_n;
      fill  <= (hit && !ovl_r) ? '0 : fill_n;
      match <= hit;
    end else begin
      match <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_count <= '0;
    else if (clr_count)
      match_count <= hit ? CNT_W'(1) : '0;
    else if (hit && match_count != CNT_SAT)
      match_count <= match_count + CNT_W'(1);
  end

endmodule
